// File: rtl/icache_fill_if.sv
// Fetch-side and memory-side handshake bundle for icache_fill.
// slave = the cache's view; master = the fetch unit / memory controller side.
interface icache_fill_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 1
);
    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;

    logic                    IF2IC_en;
    logic [ADDR_WIDTH-1:0]   IF2IC_addr;
    logic                    IC2IF_en;
    logic [31:0]             IC2IF_inst;
    logic                    IC2MC_en;
    logic [ADDR_WIDTH-1:0]   IC2MC_addr;
    logic [32*BLOCK_SIZE-1:0] MC2IC_block;
    logic                    MC2IC_en;

    modport slave (
        input  IF2IC_en, IF2IC_addr, MC2IC_block, MC2IC_en,
        output IC2IF_en, IC2IF_inst, IC2MC_en, IC2MC_addr
    );

    modport master (
        output IF2IC_en, IF2IC_addr, MC2IC_block, MC2IC_en,
        input  IC2IF_en, IC2IF_inst, IC2MC_en, IC2MC_addr
    );
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with single-outstanding block fill.
// Optional hit/miss counters enabled by defining ICACHE_STAT_EN.
module icache_fill #(
    parameter int BLOCK_WIDTH = 1,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
    parameter int CACHE_SIZE  = 8,
    parameter int BLOCK_NUM   = 1 << CACHE_SIZE,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    icache_fill_if.slave bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IDX_LO = BLOCK_WIDTH + 2;
    localparam int TAG_LO = IDX_LO + CACHE_SIZE;
    localparam int TAG_W  = ADDR_WIDTH - TAG_LO;

    typedef enum logic {IDLE, MISS} state_t;
    typedef logic [BLOCK_SIZE-1:0][31:0] line_t;

    state_t                  state;
    line_t                   data_mem [BLOCK_NUM];
    logic [TAG_W-1:0]        tag_mem  [BLOCK_NUM];
    logic [BLOCK_NUM-1:0]    valid;
    logic                    discard;

    logic [TAG_W-1:0]        miss_tag;
    logic [CACHE_SIZE-1:0]   miss_idx;
    logic [BLOCK_WIDTH-1:0]  miss_off;

    logic [TAG_W-1:0]        req_tag;
    logic [CACHE_SIZE-1:0]   req_idx;
    logic [BLOCK_WIDTH-1:0]  req_off;
    logic                    hit, accept, fill;
    line_t                   hit_line, fill_line;
    logic                    unused_addr_bits;

    assign req_tag   = bus.IF2IC_addr[ADDR_WIDTH-1:TAG_LO];
    assign req_idx   = bus.IF2IC_addr[TAG_LO-1:IDX_LO];
    assign req_off   = bus.IF2IC_addr[IDX_LO-1:2];
    assign unused_addr_bits = ^bus.IF2IC_addr[1:0];

    assign hit_line  = data_mem[req_idx];
    assign fill_line = line_t'(bus.MC2IC_block);
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    // IC2IF_en high means the fetch unit is still retiring the last request
    assign accept    = (state == IDLE) && bus.IF2IC_en && !bus.IC2IF_en && !clear_in;
    assign fill      = (state == MISS) && bus.MC2IC_en;

    // Arrays carry no reset; a fill is blocked on the reset cycle itself
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill) begin
            data_mem[miss_idx] <= fill_line;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            valid          <= '0;
            discard        <= 1'b0;
            bus.IC2IF_en   <= 1'b0;
            bus.IC2IF_inst <= '0;
            bus.IC2MC_en   <= 1'b0;
            bus.IC2MC_addr <= '0;
`ifdef ICACHE_STAT_EN
            hit_cnt        <= '0;
            miss_cnt       <= '0;
`endif
        end else if (rdy_in) begin
            bus.IC2IF_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            bus.IC2IF_en   <= 1'b1;
                            bus.IC2IF_inst <= hit_line[req_off];
`ifdef ICACHE_STAT_EN
                            hit_cnt        <= hit_cnt + 32'd1;
`endif
                        end else begin
                            miss_tag       <= req_tag;
                            miss_idx       <= req_idx;
                            miss_off       <= req_off;
                            bus.IC2MC_en   <= 1'b1;
                            bus.IC2MC_addr <= {bus.IF2IC_addr[ADDR_WIDTH-1:IDX_LO], {IDX_LO{1'b0}}};
                            state          <= MISS;
`ifdef ICACHE_STAT_EN
                            miss_cnt       <= miss_cnt + 32'd1;
`endif
                        end
                    end
                end
                MISS: begin
                    if (clear_in) discard <= 1'b1;
                    if (bus.MC2IC_en) begin
                        valid[miss_idx] <= 1'b1;
                        bus.IC2MC_en    <= 1'b0;
                        discard         <= 1'b0;
                        state           <= IDLE;
                        // Forward from the returned block rather than the array
                        if (!discard && !clear_in) begin
                            bus.IC2IF_en   <= 1'b1;
                            bus.IC2IF_inst <= fill_line[miss_off];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fill.sv
// Directed test of icache_fill: miss/hit/conflict/flush/stall/reset paths.
module tb_icache_fill;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clear_in;
    int   n_chk = 0;
    int   n_err = 0;

    icache_fill_if #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) bus ();

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_fill dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus.slave)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One MC2IC_en pulse carrying blk
    task automatic mem_return(input logic [63:0] blk);
        bus.MC2IC_block = blk;
        bus.MC2IC_en    = 1'b1;
        step();
        bus.MC2IC_en    = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        bus.IF2IC_en = 1'b0; bus.IF2IC_addr = '0;
        bus.MC2IC_en = 1'b0; bus.MC2IC_block = '0;
        step(); step();
        check("rst_if_en",   64'(bus.IC2IF_en),   64'd0);
        check("rst_inst",    64'(bus.IC2IF_inst), 64'd0);
        check("rst_mc_en",   64'(bus.IC2MC_en),   64'd0);
        check("rst_mc_addr", 64'(bus.IC2MC_addr), 64'd0);
        rst_in = 1'b0;

        // Cold miss on 0x04
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0004;
        step();
        check("cold_mc_en",   64'(bus.IC2MC_en),   64'd1);
        check("cold_mc_addr", 64'(bus.IC2MC_addr), 64'h0);
        check("cold_no_resp", 64'(bus.IC2IF_en),   64'd0);
        mem_return(64'h00300093_00100013);
        check("cold_resp",    64'(bus.IC2IF_en),   64'd1);
        check("cold_inst",    64'(bus.IC2IF_inst), 64'h00300093);
        check("cold_mc_drop", 64'(bus.IC2MC_en),   64'd0);
        bus.IF2IC_en = 1'b0;
        step();
        check("cold_pulse",   64'(bus.IC2IF_en),   64'd0);

        // Hit on 0x00, request held high across the response pulse
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0000;
        step();
        check("hit_resp",     64'(bus.IC2IF_en),   64'd1);
        check("hit_inst",     64'(bus.IC2IF_inst), 64'h00100013);
        check("hit_no_mc",    64'(bus.IC2MC_en),   64'd0);
        step();
        check("hold_no_dup",  64'(bus.IC2IF_en),   64'd0);
        bus.IF2IC_en = 1'b0;
        step();
        check("hold_quiet",   64'(bus.IC2IF_en),   64'd0);

        // Conflict miss 0x800, with a 5-cycle stall mid-miss
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0800;
        step();
        check("conf_mc_en",   64'(bus.IC2MC_en),   64'd1);
        check("conf_mc_addr", 64'(bus.IC2MC_addr), 64'h800);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_mc_en",   64'(bus.IC2MC_en),   64'd1);
            check("stall_mc_addr", 64'(bus.IC2MC_addr), 64'h800);
        end
        rdy_in = 1'b1;
        mem_return(64'hAAAA0001_BBBB0002);
        check("conf_resp",    64'(bus.IC2IF_en),   64'd1);
        check("conf_inst",    64'(bus.IC2IF_inst), 64'hBBBB0002);
        bus.IF2IC_en = 1'b0;
        step();

        // 0x00 was evicted: must miss again
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0000;
        step();
        check("evict_mc_en",   64'(bus.IC2MC_en),   64'd1);
        check("evict_mc_addr", 64'(bus.IC2MC_addr), 64'h0);
        check("evict_no_resp", 64'(bus.IC2IF_en),   64'd0);
        mem_return(64'h00300093_00100013);
        check("evict_inst",    64'(bus.IC2IF_inst), 64'h00100013);
        bus.IF2IC_en = 1'b0;
        step();

        // Flush while missing on 0x10: line fills, response dropped
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0010;
        step();
        check("fl_mc_addr",   64'(bus.IC2MC_addr), 64'h10);
        clear_in = 1'b1;
        step();
        clear_in = 1'b0; bus.IF2IC_en = 1'b0;
        check("fl_mc_held",   64'(bus.IC2MC_en),   64'd1);
        mem_return(64'h11112222_33334444);
        check("fl_no_resp",   64'(bus.IC2IF_en),   64'd0);
        check("fl_mc_drop",   64'(bus.IC2MC_en),   64'd0);
        step();
        check("fl_quiet",     64'(bus.IC2IF_en),   64'd0);
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0010;
        step();
        check("fl_hit_resp",  64'(bus.IC2IF_en),   64'd1);
        check("fl_hit_inst",  64'(bus.IC2IF_inst), 64'h33334444);
        check("fl_hit_no_mc", 64'(bus.IC2MC_en),   64'd0);
        bus.IF2IC_en = 1'b0;
        step();
`ifdef ICACHE_STAT_EN
        check("hit_cnt",  64'(hit_cnt),  64'd2);
        check("miss_cnt", 64'(miss_cnt), 64'd4);
`endif

        // Fill coinciding with clear on 0x18, then upper word of that line hits
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0018;
        step();
        check("cc_mc_addr",   64'(bus.IC2MC_addr), 64'h18);
        clear_in = 1'b1;
        mem_return(64'h5555AAAA_66667777);
        clear_in = 1'b0; bus.IF2IC_en = 1'b0;
        check("cc_no_resp",   64'(bus.IC2IF_en),   64'd0);
        step();
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_001C;
        step();
        check("cc_hit_inst",  64'(bus.IC2IF_inst), 64'h5555AAAA);
        check("cc_hit_resp",  64'(bus.IC2IF_en),   64'd1);
        bus.IF2IC_en = 1'b0;
        step();

        // Stray MC2IC_en while idle is ignored
        mem_return(64'hDEADBEEF_DEADBEEF);
        check("idle_mc_resp", 64'(bus.IC2IF_en),   64'd0);
        check("idle_mc_en",   64'(bus.IC2MC_en),   64'd0);

        // Reset mid-miss invalidates everything; late return ignored
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0020;
        step();
        check("rm_mc_en",     64'(bus.IC2MC_en),   64'd1);
        bus.IF2IC_en = 1'b0; rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("rm_mc_drop",   64'(bus.IC2MC_en),   64'd0);
        mem_return(64'h12345678_9ABCDEF0);
        check("rm_late_resp", 64'(bus.IC2IF_en),   64'd0);
        bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h0000_0010;
        step();
        check("rm_inval_miss", 64'(bus.IC2MC_en),  64'd1);
        check("rm_inval_resp", 64'(bus.IC2IF_en),  64'd0);
        bus.IF2IC_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
